fft_bin_scanner: RTL and testbench

//   Downstream consumer of the 8-point DIT FFT core. Drives the core's bin-select input,

---
 rtl/fft_pkg.sv | 15 +
 rtl/fft_mag_calc.sv | 38 +++
 rtl/fft_bin_scanner.sv | 150 +++++++++++++++
 tb/tb_fft_bin_scanner.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and scanner state encoding for the FFT bin scanner.
package fft_pkg;
  localparam int FFT_DW     = 12;
  localparam int FFT_N_BINS = 8;
  localparam int FFT_SEL_W  = 3;
  localparam int MAG_W      = 2 * FFT_DW;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_EMIT    = 3'd3,
    ST_DONE    = 3'd4
  } scan_state_e;
endpackage

// File: rtl/fft_mag_calc.sv
// Combinational per-bin magnitude.
// FFT_SCAN_APPROX_MAG_EN selects max(|yr|,|yi|) + min(|yr|,|yi|)/2 (no multipliers);
// otherwise the exact sum of squares yr^2 + yi^2.
module fft_mag_calc
  import fft_pkg::*;
#(
  parameter int DW = FFT_DW
) (
  input  logic signed [DW-1:0]   yr,
  input  logic signed [DW-1:0]   yi,
  output logic        [2*DW-1:0] mag
);
`ifdef FFT_SCAN_APPROX_MAG_EN
  // One extra bit so |-2^(DW-1)| is representable.
  logic [DW:0] yr_x, yi_x, ar, ai, mx, mn, sum;

  // Absolute values, then max + min/2; result is at most 1.5 * 2^(DW-1).
  always_comb begin
    yr_x = {yr[DW-1], yr};
    yi_x = {yi[DW-1], yi};
    ar   = yr_x[DW] ? (~yr_x + 1'b1) : yr_x;
    ai   = yi_x[DW] ? (~yi_x + 1'b1) : yi_x;
    mx   = (ar > ai) ? ar : ai;
    mn   = (ar > ai) ? ai : ar;
    sum  = mx + (mn >> 1);
    mag  = {{(DW-1){1'b0}}, sum};
  end
`else
  logic signed [2*DW-1:0] sq_r, sq_i;

  // Each square fits the signed 2*DW range; the sum only fits as unsigned.
  always_comb begin
    sq_r = yr * yr;
    sq_i = yi * yi;
    mag  = $unsigned(sq_r) + $unsigned(sq_i);
  end
`endif
endmodule

// File: rtl/fft_bin_scanner.sv
// Sweeps the FFT core's bin select, samples each settled bin, streams (bin, magnitude)
// over valid/ready and reports the peak bin of each completed sweep.
// Magnitude flavour is chosen by FFT_SCAN_APPROX_MAG_EN inside fft_mag_calc.
module fft_bin_scanner
  import fft_pkg::*;
#(
  parameter int DW     = FFT_DW,
  parameter int N_BINS = FFT_N_BINS,
  parameter int SETTLE = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic [$clog2(N_BINS)-1:0]   sel,
  input  logic signed [DW-1:0]        yr,
  input  logic signed [DW-1:0]        yi,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(N_BINS)-1:0]   out_bin,
  output logic [2*DW-1:0]             out_mag,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(N_BINS)-1:0]   peak_bin,
  output logic [2*DW-1:0]             peak_mag
);
  localparam int SEL_W = $clog2(N_BINS);
  localparam int MW    = 2 * DW;
  localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE);

  localparam logic [SEL_W-1:0] LAST_BIN   = SEL_W'(N_BINS - 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);

  scan_state_e      state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             ov_q, ov_d;
  logic [SEL_W-1:0] ob_q, ob_d;
  logic [MW-1:0]    om_q, om_d;
  logic [SEL_W-1:0] run_bin_q, run_bin_d;
  logic [MW-1:0]    run_mag_q, run_mag_d;
  logic [SEL_W-1:0] pk_bin_q, pk_bin_d;
  logic [MW-1:0]    pk_mag_q, pk_mag_d;
  logic [MW-1:0]    mag;

  fft_mag_calc #(.DW(DW)) u_mag (
    .yr  (yr),
    .yi  (yi),
    .mag (mag)
  );

  // Next-state and datapath updates for the sweep FSM.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    ov_d      = ov_q;
    ob_d      = ob_q;
    om_d      = om_q;
    run_bin_d = run_bin_q;
    run_mag_d = run_mag_q;
    pk_bin_d  = pk_bin_q;
    pk_mag_d  = pk_mag_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SETTLE;
          sel_d     = '0;
          busy_d    = 1'b1;
          cnt_d     = CNT_RELOAD;
          run_bin_d = '0;
          run_mag_d = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_CAPTURE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_CAPTURE: begin
        om_d    = mag;
        ob_d    = sel_q;
        ov_d    = 1'b1;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_ready) begin
          ov_d = 1'b0;
          // Strictly greater: ties keep the earlier (lower) bin.
          if (om_q > run_mag_q) begin
            run_bin_d = ob_q;
            run_mag_d = om_q;
          end
          if (sel_q == LAST_BIN) begin
            state_d = ST_DONE;
          end else begin
            sel_d   = sel_q + 1'b1;
            cnt_d   = CNT_RELOAD;
            state_d = ST_SETTLE;
          end
        end
      end
      ST_DONE: begin
        pk_bin_d = run_bin_q;
        pk_mag_d = run_mag_q;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      ov_q      <= 1'b0;
      ob_q      <= '0;
      om_q      <= '0;
      run_bin_q <= '0;
      run_mag_q <= '0;
      pk_bin_q  <= '0;
      pk_mag_q  <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      ov_q      <= ov_d;
      ob_q      <= ob_d;
      om_q      <= om_d;
      run_bin_q <= run_bin_d;
      run_mag_q <= run_mag_d;
      pk_bin_q  <= pk_bin_d;
      pk_mag_q  <= pk_mag_d;
    end
  end

  assign sel       = sel_q;
  assign out_valid = ov_q;
  assign out_bin   = ob_q;
  assign out_mag   = om_q;
  assign busy      = busy_q;
  assign done      = (state_q == ST_DONE);
  assign peak_bin  = pk_bin_q;
  assign peak_mag  = pk_mag_q;
endmodule

// File: tb/tb_fft_bin_scanner.sv
// Self-checking bench for fft_bin_scanner: table sweep, ramp, backpressure, tie,
// start-while-busy, mid-sweep reset and random sweeps against a magnitude model.
module tb_fft_bin_scanner;
  localparam int DW     = 12;
  localparam int SW     = 3;
  localparam int MW     = 24;
  localparam int SETTLE = 2;

  logic                 clk = 1'b0;
  logic                 rst, start, out_ready;
  logic [SW-1:0]        sel, out_bin, peak_bin;
  logic signed [DW-1:0] yr, yi;
  logic                 out_valid, busy, done;
  logic [MW-1:0]        out_mag, peak_mag;

  int yr_tab[8];
  int yi_tab[8];

  assign yr = yr_tab[sel][DW-1:0];
  assign yi = yi_tab[sel][DW-1:0];

  fft_bin_scanner #(.DW(DW), .N_BINS(8), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel), .yr(yr), .yi(yi),
    .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin), .out_mag(out_mag),
    .busy(busy), .done(done), .peak_bin(peak_bin), .peak_mag(peak_mag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint ref_mag(input int r, input int i);
`ifdef FFT_SCAN_APPROX_MAG_EN
    int a, b;
    a = (r < 0) ? -r : r;
    b = (i < 0) ? -i : i;
    return (a > b) ? longint'(a + b / 2) : longint'(b + a / 2);
`else
    return longint'(r) * r + longint'(i) * i;
`endif
  endfunction

  int     got_bin[$];
  longint got_mag[$];
  int     rise_cyc[$];
  int     done_cnt;

  // Runs one sweep, recording accepted results; returns at the cycle after done.
  // mode 0: ready high, 1: random ready, 2: ready low 5 cycles at bin 2.
  task automatic run_sweep(input int mode, input bit do_start, input bit hold_start,
                           input string tag);
    int cyc = 0, after = -1, lowcnt = 0, pbin = 0;
    bit pv = 0, pr = 0, fin = 0, bp_done = 0;
    longint pmag = 0;
    got_bin.delete(); got_mag.delete(); rise_cyc.delete(); done_cnt = 0;
    @(negedge clk);
    if (do_start) start = 1'b1;
    while (!fin && cyc < 2000) begin
      if (cyc == 1 && !hold_start) start = 1'b0;
      case (mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (out_valid && out_bin == 3'd2 && !bp_done) begin
            if (lowcnt < 5) begin out_ready = 1'b0; lowcnt++; end
            else begin out_ready = 1'b1; bp_done = 1'b1; end
          end else out_ready = 1'b1;
          if (!out_ready) chk({tag, " bp_sel"}, sel, 2);
        end
        default: out_ready = 1'b1;
      endcase
      if (pv && !pr) begin
        chk({tag, " hold_valid"}, out_valid, 1);
        chk({tag, " hold_bin"}, out_bin, pbin);
        chk({tag, " hold_mag"}, out_mag, pmag);
      end
      if (out_valid && !pv) rise_cyc.push_back(cyc);
      if (out_valid && out_ready) begin
        got_bin.push_back(int'(out_bin));
        got_mag.push_back(longint'(out_mag));
      end
      if (done) begin done_cnt++; after = cyc + 1; end
      else if (cyc == after) begin
        fin = 1'b1;
        chk({tag, " busy_after_done"}, busy, 0);
      end
      pv = out_valid; pr = out_ready; pbin = int'(out_bin); pmag = longint'(out_mag);
      if (!fin) begin @(posedge clk); @(negedge clk); cyc++; end
    end
    if (!fin) chk({tag, " sweep_timeout"}, 0, 1);
    if (mode == 2) chk({tag, " bp_cycles"}, lowcnt, 5);
    if (mode == 0 && do_start) begin
      chk({tag, " first_latency"}, rise_cyc.size() > 0 ? rise_cyc[0] : -1, SETTLE + 2);
      for (int k = 1; k < rise_cyc.size(); k++)
        chk({tag, " bin_spacing"}, rise_cyc[k] - rise_cyc[k-1], SETTLE + 2);
    end
  endtask

  task automatic check_sweep(input string tag, input longint em[8],
                             input int epb, input longint epm);
    chk({tag, " n_results"}, got_bin.size(), 8);
    for (int b = 0; b < 8 && b < got_bin.size(); b++) begin
      chk($sformatf("%s bin%0d idx", tag, b), got_bin[b], b);
      chk($sformatf("%s bin%0d mag", tag, b), got_mag[b], em[b]);
    end
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " peak_bin"}, peak_bin, epb);
    chk({tag, " peak_mag"}, peak_mag, epm);
  endtask

  // Model-driven sweep expectations: per-bin magnitude and strict-greater peak scan.
  task automatic check_model(input string tag);
    longint em[8];
    int epb = 0;
    longint epm = 0;
    for (int b = 0; b < 8; b++) begin
      em[b] = ref_mag(yr_tab[b], yi_tab[b]);
      if (em[b] > epm) begin epm = em[b]; epb = b; end
    end
    check_sweep(tag, em, epb, epm);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, " sel"}, sel, 0);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_bin"}, out_bin, 0);
    chk({tag, " out_mag"}, out_mag, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " peak_bin"}, peak_bin, 0);
    chk({tag, " peak_mag"}, peak_mag, 0);
  endtask

  typedef struct {
    int     yr;
    int     yi;
    longint mag_exact;
    longint mag_approx;
  } vec_t;

  initial begin
    vec_t   vt[8];
    longint em[8];
    int     waitc;
    bit     done_seen;

    vt[0] = '{300, -400, 250000, 550};
    vt[1] = '{-2048, -2048, 8388608, 3072};
    vt[2] = '{0, 0, 0, 0};
    vt[3] = '{2047, 0, 4190209, 2047};
    vt[4] = '{-1, 1, 2, 1};
    vt[5] = '{100, -100, 20000, 150};
    vt[6] = '{-2048, 2047, 8384513, 3071};
    vt[7] = '{5, 12, 169, 14};

    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin yr_tab[b] = 0; yi_tab[b] = 0; end
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    check_idle_zero("reset");

    // Table-driven sweep with random backpressure.
    for (int b = 0; b < 8; b++) begin
      yr_tab[b] = vt[b].yr; yi_tab[b] = vt[b].yi;
`ifdef FFT_SCAN_APPROX_MAG_EN
      em[b] = vt[b].mag_approx;
`else
      em[b] = vt[b].mag_exact;
`endif
    end
    run_sweep(1, 1, 0, "table");
`ifdef FFT_SCAN_APPROX_MAG_EN
    check_sweep("table", em, 1, 3072);
`else
    check_sweep("table", em, 1, 8388608);
`endif

    // Ramp: yr = bin*100, ready tied high; latency and spacing checked.
    for (int b = 0; b < 8; b++) begin yr_tab[b] = b * 100; yi_tab[b] = 0; end
    run_sweep(0, 1, 0, "ramp");
    check_model("ramp");

    // Backpressure held 5 cycles at bin 2.
    for (int b = 0; b < 8; b++) begin
      yr_tab[b] = int'($urandom_range(0, 4095)) - 2048;
      yi_tab[b] = int'($urandom_range(0, 4095)) - 2048;
    end
    run_sweep(2, 1, 0, "bp");
    check_model("bp");

    // Tie at the most negative value: lower bin wins.
    for (int b = 0; b < 8; b++) begin yr_tab[b] = 0; yi_tab[b] = 0; end
    yr_tab[1] = -2048; yi_tab[1] = -2048; yr_tab[5] = -2048; yi_tab[5] = -2048;
    run_sweep(0, 1, 0, "tie");
`ifdef FFT_SCAN_APPROX_MAG_EN
    chk("tie peak_mag const", peak_mag, 3072);
`else
    chk("tie peak_mag const", peak_mag, 8388608);
`endif
    check_model("tie");

    // Start held high through busy and the done cycle; accepted only once idle.
    for (int b = 0; b < 8; b++) begin yr_tab[b] = b * 100; yi_tab[b] = 0; end
    run_sweep(0, 1, 1, "hold");
    check_model("hold");
    @(posedge clk); @(negedge clk);
    chk("restart busy", busy, 1);
    chk("restart sel", sel, 0);
    start = 1'b0;
    run_sweep(0, 0, 0, "restart");
    check_model("restart");

    // Reset held 3 cycles while sel is at bin 4.
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    waitc = 0; done_seen = 1'b0;
    while (sel != 3'd4 && waitc < 200) begin
      if (done) done_seen = 1'b1;
      @(negedge clk); waitc++;
    end
    chk("midrst reached_bin4", sel, 4);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_zero("midrst");
    chk("midrst no_done", done_seen, 0);
    @(negedge clk);
    chk("midrst stays_idle busy", busy, 0);
    chk("midrst stays_idle done", done, 0);

    // Random sweeps with random ready.
    for (int s = 0; s < 4; s++) begin
      for (int b = 0; b < 8; b++) begin
        yr_tab[b] = int'($urandom_range(0, 4095)) - 2048;
        yi_tab[b] = int'($urandom_range(0, 4095)) - 2048;
      end
      run_sweep(1, 1, 0, $sformatf("rand%0d", s));
      check_model($sformatf("rand%0d", s));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
